// File: rtl/button_input_conditioner.sv
// button_input_conditioner: sync, debounce and edge-detect raw devboard buttons.
// Ports: clock, reset, rawIn, clearPress -> level, pressPulse, releasePulse, pressLatched.
module button_input_conditioner #(
  parameter int NUM_INPUTS    = 4,
  parameter int STABLE_CYCLES = 500000,
  parameter bit ACTIVE_LOW    = 1'b1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NUM_INPUTS-1:0] rawIn,
  input  logic [NUM_INPUTS-1:0] clearPress,
  output logic [NUM_INPUTS-1:0] level,
  output logic [NUM_INPUTS-1:0] pressPulse,
  output logic [NUM_INPUTS-1:0] releasePulse,
  output logic [NUM_INPUTS-1:0] pressLatched
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [NUM_INPUTS-1:0] IDLE =
    ACTIVE_LOW ? {NUM_INPUTS{1'b1}} : {NUM_INPUTS{1'b0}};

  logic [NUM_INPUTS-1:0] sync1_q, sync2_q;
  logic [NUM_INPUTS-1:0] synced;
  logic [NUM_INPUTS-1:0] level_q, level_d;
  logic [NUM_INPUTS-1:0] press_q, press_d;
  logic [NUM_INPUTS-1:0] rel_q, rel_d;
  logic [NUM_INPUTS-1:0] latch_q, latch_d;
  logic [NUM_INPUTS-1:0][CW-1:0] cnt_q, cnt_d;

  // Normalized so that 1 always means pressed.
  assign synced = ACTIVE_LOW ? ~sync2_q : sync2_q;

  always_comb begin
    level_d = level_q;
    cnt_d   = cnt_q;
    press_d = '0;
    rel_d   = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (synced[i] == level_q[i]) begin
        // Any agreement restarts the run, so bounces never add up.
        cnt_d[i] = '0;
      end else if (cnt_q[i] != LAST) begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end else begin
        level_d[i] = synced[i];
        cnt_d[i]   = '0;
        press_d[i] = synced[i];
        rel_d[i]   = ~synced[i];
      end
    end
    // A press in the same cycle as a clear keeps the latch set.
    latch_d = press_d | (latch_q & ~clearPress);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q <= IDLE;
      sync2_q <= IDLE;
      level_q <= '0;
      press_q <= '0;
      rel_q   <= '0;
      latch_q <= '0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= rawIn;
      sync2_q <= sync1_q;
      level_q <= level_d;
      press_q <= press_d;
      rel_q   <= rel_d;
      latch_q <= latch_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level        = level_q;
  assign pressPulse   = press_q;
  assign releasePulse = rel_q;
  assign pressLatched = latch_q;

endmodule
